stepper_step_gen: RTL and testbench

- Motion-profile stage directly upstream of the 4-phase stepper sequencer.
- Accepts a move command (step count, direction) over a valid/ready handshake.
- Emits single-cycle step pulses plus a stable direction level, spaced by a trapezoidal accel/cruise/decel interval profile.
- The sequencer advances one phase per step pulse; the piano control logic issues commands.

---
 rtl/stepper_step_gen_pkg.sv | 18 +
 rtl/stepper_interval_timer.sv | 33 +++
 rtl/stepper_step_gen.sv | 141 ++++++++++++++
 tb/tb_stepper_step_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stepper_step_gen_pkg.sv
// Shared definitions for the stepper motion-profile stage.
// Holds the FSM state encoding and the default profile constants, so the
// piano top level can use the same values when it configures the block.
package stepper_step_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } step_state_e;

  localparam int DEF_STEP_W    = 16;
  localparam int DEF_DIV_W     = 24;
  localparam int DEF_START_DIV = 50000;
  localparam int DEF_MIN_DIV   = 10000;
  localparam int DEF_RAMP_DEC  = 500;

endpackage

// File: rtl/stepper_interval_timer.sv
// Loadable down-counter that sets the spacing between step pulses.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - replace the count with load_val on the next edge
//   load_val  - value to load
//   tick      - high while the count is zero
// The count holds at zero until it is loaded again.
module stepper_interval_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)                count_d = load_val;
    else if (count_q != '0)  count_d = count_q - DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/stepper_step_gen.sv
// Trapezoidal step generator feeding the 4-phase stepper sequencer.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   - move command handshake (ready only when idle)
//   cmd_steps, cmd_dir    - step count and direction of the move
//   abort                 - controlled stop request, sampled every cycle
//   step_pulse            - one-cycle pulse per step
//   step_dir              - direction level, constant for a whole move
//   busy                  - a move is in progress
//   done                  - one-cycle pulse at move completion or abort
//   steps_left            - steps still to be issued
// ramp_cnt counts how many accel steps have been taken, so decel starts
// once the remaining steps no longer exceed it (symmetric ramps).
module stepper_step_gen
  import stepper_step_gen_pkg::*;
#(
  parameter int STEP_W    = DEF_STEP_W,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int START_DIV = DEF_START_DIV,
  parameter int MIN_DIV   = DEF_MIN_DIV,
  parameter int RAMP_DEC  = DEF_RAMP_DEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              abort,
  output logic              step_pulse,
  output logic              step_dir,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  // Period math one bit wider than the interval so +/- RAMP_DEC never wraps.
  localparam logic [DIV_W:0] START_W = (DIV_W+1)'(START_DIV);
  localparam logic [DIV_W:0] MIN_W   = (DIV_W+1)'(MIN_DIV);
  localparam logic [DIV_W:0] DEC_W   = (DIV_W+1)'(RAMP_DEC);

  step_state_e       state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] left_q, left_d;
  logic [STEP_W-1:0] ramp_q, ramp_d;
  logic [DIV_W-1:0]  period_q, period_d;

  logic              tmr_load;
  logic [DIV_W-1:0]  tmr_val;
  logic              tick;

  logic [STEP_W-1:0] left_v, ramp_v;
  logic [DIV_W:0]    per_w;

  stepper_interval_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    left_d     = left_q;
    ramp_d     = ramp_q;
    period_d   = period_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    step_pulse = 1'b0;
    left_v     = left_q;
    ramp_v     = ramp_q;
    per_w      = {1'b0, period_q};
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          left_d   = cmd_steps;
          ramp_d   = '0;
          period_d = START_W[DIV_W-1:0];
          tmr_load = 1'b1;   // timer 0: first pulse in the cycle after accept
          state_d  = (cmd_steps == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          step_pulse = 1'b1;
          left_v     = left_q - STEP_W'(1);
          if (left_v == '0) begin
            state_d = ST_FIN;
          end else if (left_v <= ramp_q) begin
            per_w  = {1'b0, period_q} + DEC_W;
            if (per_w > START_W) per_w = START_W;
            ramp_v = ramp_q - STEP_W'(1);
          end else if ({1'b0, period_q} > MIN_W) begin
            if ({1'b0, period_q} <= MIN_W + DEC_W) per_w = MIN_W;
            else                                   per_w = {1'b0, period_q} - DEC_W;
            ramp_v = ramp_q + STEP_W'(1);
          end
          period_d = per_w[DIV_W-1:0];
          tmr_load = 1'b1;
          tmr_val  = per_w[DIV_W-1:0] - DIV_W'(1);
        end
        // Abort truncates to the decel ramp after any same-cycle pulse update;
        // the running interval is left alone.
        if (abort && state_d == ST_RUN) begin
          if (left_v > ramp_v) left_v = ramp_v;
          if (ramp_v == '0)    state_d = ST_FIN;
        end
        left_d = left_v;
        ramp_d = ramp_v;
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      left_q   <= '0;
      ramp_q   <= '0;
      period_q <= START_W[DIV_W-1:0];
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      left_q   <= left_d;
      ramp_q   <= ramp_d;
      period_q <= period_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign step_dir   = dir_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
module tb_stepper_step_gen;

  localparam int STEP_W = 16;
  localparam int DIV_W  = 24;
  localparam int SDIV   = 8;
  localparam int MDIV   = 4;
  localparam int DEC    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              cmd_dir = 1'b0;
  logic              abort = 1'b0;
  logic              step_pulse, step_dir, busy, done;
  logic [STEP_W-1:0] steps_left;

  stepper_step_gen #(
    .STEP_W(STEP_W), .DIV_W(DIV_W), .START_DIV(SDIV), .MIN_DIV(MDIV), .RAMP_DEC(DEC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort),
    .step_pulse(step_pulse), .step_dir(step_dir), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; bit dn; bit dir; int left; } ev_t;
  ev_t q[$];
  ev_t e;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(int t, bit dn, bit dir, int left);
    ev_t x;
    x.t = t; x.dn = dn; x.dir = dir; x.left = left;
    q.push_back(x);
  endtask

  // Event-level reference: walks the move step by step, placing each pulse
  // at previous pulse + updated interval; ab is the abort cycle offset from
  // accept (0 = no abort).
  task automatic model(int t0, int steps, bit dir, int ab);
    int left, period, ramp, t, nt, a;
    a = (ab > 0) ? t0 + ab : -1;
    if (steps == 0) begin push(t0 + 1, 1, dir, 0); return; end
    left = steps; period = SDIV; ramp = 0; t = t0 + 1;
    forever begin
      push(t, 0, dir, left);
      left--;
      if (left == 0) begin push(t + 1, 1, dir, 0); return; end
      if (left <= ramp) begin
        period = (period + DEC > SDIV) ? SDIV : period + DEC;
        ramp--;
      end else if (period > MDIV) begin
        period = (period - DEC < MDIV) ? MDIV : period - DEC;
        ramp++;
      end
      nt = t + period;
      if (a >= t && a < nt) begin
        if (left > ramp) left = ramp;
        if (left == 0) begin push(a + 1, 1, dir, 0); return; end
      end
      t = nt;
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    while (q.size() > 0 && q[0].t < cyc) begin
      chk("missed_event_cycle", cyc, q[0].t);
      void'(q.pop_front());
    end
    if (step_pulse || done) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("ev_time", cyc, e.t);
        chk("ev_done", int'(done), int'(e.dn));
        chk("ev_pulse", int'(step_pulse), int'(!e.dn));
        chk("ev_dir", int'(step_dir), int'(e.dir));
        chk("ev_steps_left", int'(steps_left), e.left);
        chk("ev_busy", int'(busy), 1);
      end
    end
    chk("ready_vs_busy", int'(cmd_ready), int'(!busy));
  end

  // Called at a negedge; holds cmd_valid until accepted, returns accept cycle.
  task automatic issue(int steps, bit dir, output int t0);
    int k;
    cmd_steps = STEP_W'(steps); cmd_dir = dir; cmd_valid = 1'b1;
    for (k = 0; k < 3000; k++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (k == 3000) chk("accept_timeout", 0, 1);
    t0 = cyc;
  endtask

  task automatic drain(int t0, int ab);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = (ab > 0 && cyc == t0 + ab);
      if (q.size() == 0 && cmd_ready) break;
    end
    abort = 1'b0;
    if (k == 3000) chk("drain_timeout", 0, 1);
  endtask

  task automatic push_profile6(int t0, bit dir);
    int pt[6] = '{1, 7, 11, 15, 21, 29};
    for (int i = 0; i < 6; i++) push(t0 + pt[i], 0, dir, 6 - i);
    push(t0 + 30, 1, dir, 0);
  endtask

  initial begin
    int t0, t1, steps, ab;
    bit dir;
    #1;
    chk("rst_step_pulse", int'(step_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    chk("rst_step_dir", int'(step_dir), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Full 6-step trapezoid.
    issue(6, 1, t0); push_profile6(t0, 1); drain(t0, 0);

    // Zero-step command: done only, ready again two cycles after accept.
    issue(0, 1, t0); push(t0 + 1, 1, 1, 0); drain(t0, 0);
    chk("zero_ready_cycle", cyc, t0 + 2);

    // Abort after the third pulse of a long move.
    issue(100, 0, t0);
    push(t0 + 1, 0, 0, 100); push(t0 + 7, 0, 0, 99); push(t0 + 11, 0, 0, 98);
    push(t0 + 15, 0, 0, 2);  push(t0 + 21, 0, 0, 1); push(t0 + 22, 1, 0, 0);
    drain(t0, 12);

    // Abort coinciding with the first pulse.
    issue(10, 1, t0);
    push(t0 + 1, 0, 1, 10); push(t0 + 7, 0, 1, 1); push(t0 + 8, 1, 1, 0);
    drain(t0, 1);

    // Second command held valid during a move.
    issue(6, 1, t0); push_profile6(t0, 1);
    @(negedge clk);
    cmd_steps = 3; cmd_dir = 1'b0;
    chk("held_ready_low", int'(cmd_ready), 0);
    issue(3, 0, t1);
    chk("held_accept_cycle", t1, t0 + 31);
    model(t1, 3, 0, 0);
    drain(t1, 0);

    // Reset in the middle of a move.
    issue(20, 1, t0);
    mon_en = 1'b0;
    repeat (7) @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_pulse", int'(step_pulse), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_step_pulse", int'(step_pulse), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_steps_left", int'(steps_left), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    issue(6, 0, t0); push_profile6(t0, 0); drain(t0, 0);

    // Randomized moves against the reference model.
    for (int n = 0; n < 25; n++) begin
      steps = $urandom_range(0, 25);
      dir   = 1'($urandom_range(0, 1));
      ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 90) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(steps, dir, t0);
      model(t0, steps, dir, ab);
      drain(t0, ab);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
